// File: rtl/sparse_pkg.sv
// Shared types for the sparse dot-product engine: list element, FSM state and
// index-compare result.
package sparse_pkg;

    localparam int ELEM_IDX_W = 3;
    localparam int ELEM_VAL_W = 3;

    typedef struct packed {
        logic                  last;
        logic [ELEM_IDX_W-1:0] idx;
        logic [ELEM_VAL_W-1:0] val;
    } elem_t;

    typedef enum logic {RUN, OUT} state_e;

    typedef enum logic [1:0] {LT, EQ, GT} cmp_e;

endpackage

// File: rtl/idx_compare.sv
// Index compare stage: combinational ordering of the two list heads plus a
// registered one-cycle pulse for each consumed index match.
module idx_compare
    import sparse_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] a_idx_i,
    input  logic [IDX_W-1:0] b_idx_i,
    input  logic             match_fire_i,
    output cmp_e             cmp_o,
    output logic             eq_o
);

    logic eq_q;

    always_comb begin
        if (a_idx_i < b_idx_i) begin
            cmp_o = LT;
        end else if (a_idx_i > b_idx_i) begin
            cmp_o = GT;
        end else begin
            cmp_o = EQ;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eq_q <= 1'b0;
        end else begin
            eq_q <= match_fire_i;
        end
    end

    assign eq_o = eq_q;

endmodule

// File: rtl/sparse_dot_engine.sv
// Streaming sparse dot product: intersects two sorted (idx,val) lists and accumulates
// matched products. Build option SPARSE_DOT_ACC_SAT_EN makes the accumulator saturate.
module sparse_dot_engine
    import sparse_pkg::*;
#(
    parameter int IDX_W = 3,
    parameter int VAL_W = 3,
    parameter int ACC_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [IDX_W-1:0] a_idx,
    input  logic [VAL_W-1:0] a_val,
    input  logic             a_last,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [IDX_W-1:0] b_idx,
    input  logic [VAL_W-1:0] b_val,
    input  logic             b_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic [CNT_W-1:0] res_matches,
    output logic             eq,
    output logic             res_ovf
);

    state_e           state_q, state_d;
    logic             a_done_q, a_done_d;
    logic             b_done_q, b_done_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cmp_e             cmp;
    logic             match_fire;
    logic [2*VAL_W-1:0] prod;

    idx_compare #(.IDX_W(IDX_W)) u_cmp (
        .clk          (clk),
        .reset        (reset),
        .a_idx_i      (a_idx),
        .b_idx_i      (b_idx),
        .match_fire_i (match_fire),
        .cmp_o        (cmp),
        .eq_o         (eq)
    );

    assign prod = {{VAL_W{1'b0}}, a_val} * {{VAL_W{1'b0}}, b_val};

`ifdef SPARSE_DOT_ACC_SAT_EN
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum;
    assign sum     = {1'b0, acc_q} + (ACC_W+1)'(prod);
    assign res_ovf = ovf_q;
`else
    logic [ACC_W-1:0] sum;
    assign sum     = acc_q + ACC_W'(prod);
    assign res_ovf = 1'b0;
`endif

    // Handshake: merge-style advance while both lists live, drain the survivor once one ends.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        match_fire = 1'b0;
        if (state_q == RUN) begin
            if (!a_done_q && !b_done_q) begin
                if (a_valid && b_valid) begin
                    case (cmp)
                        EQ: begin
                            a_ready    = 1'b1;
                            b_ready    = 1'b1;
                            match_fire = 1'b1;
                        end
                        LT:      a_ready = 1'b1;
                        default: b_ready = 1'b1;
                    endcase
                end
            end else if (!a_done_q) begin
                a_ready = a_valid;
            end else if (!b_done_q) begin
                b_ready = b_valid;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        a_done_d = a_done_q;
        b_done_d = b_done_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`ifdef SPARSE_DOT_ACC_SAT_EN
        ovf_d    = ovf_q;
`endif
        if (state_q == RUN) begin
            if (match_fire) begin
                cnt_d = cnt_q + CNT_W'(1);
`ifdef SPARSE_DOT_ACC_SAT_EN
                if (sum[ACC_W]) begin
                    acc_d = '1;
                    ovf_d = 1'b1;
                end else begin
                    acc_d = sum[ACC_W-1:0];
                end
`else
                acc_d = sum;
`endif
            end
            if (a_ready && a_last) a_done_d = 1'b1;
            if (b_ready && b_last) b_done_d = 1'b1;
            if (a_done_d && b_done_d) state_d = OUT;
        end else if (res_ready) begin
            state_d  = RUN;
            a_done_d = 1'b0;
            b_done_d = 1'b0;
            acc_d    = '0;
            cnt_d    = '0;
`ifdef SPARSE_DOT_ACC_SAT_EN
            ovf_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            a_done_q <= 1'b0;
            b_done_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
`ifdef SPARSE_DOT_ACC_SAT_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_done_q <= a_done_d;
            b_done_q <= b_done_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`ifdef SPARSE_DOT_ACC_SAT_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign res_valid   = (state_q == OUT);
    assign res_data    = acc_q;
    assign res_matches = cnt_q;

endmodule

// File: tb/tb_sparse_dot_engine.sv
// Directed self-checking bench for sparse_dot_engine; honours SPARSE_DOT_ACC_SAT_EN
// when choosing the overflow expectations.
module tb_sparse_dot_engine;
    import sparse_pkg::*;

    localparam int IDX_W = 3;
    localparam int VAL_W = 3;
    localparam int ACC_W = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             a_valid, a_ready, a_last;
    logic [IDX_W-1:0] a_idx;
    logic [VAL_W-1:0] a_val;
    logic             b_valid, b_ready, b_last;
    logic [IDX_W-1:0] b_idx;
    logic [VAL_W-1:0] b_val;
    logic             res_valid, res_ready;
    logic [ACC_W-1:0] res_data;
    logic [CNT_W-1:0] res_matches;
    logic             eq, res_ovf;

    int checks   = 0;
    int failures = 0;

    elem_t a_list[8];
    elem_t b_list[8];
    int    na, nb;

    sparse_dot_engine #(
        .IDX_W(IDX_W), .VAL_W(VAL_W), .ACC_W(ACC_W), .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_idx       (a_idx),
        .a_val       (a_val),
        .a_last      (a_last),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_idx       (b_idx),
        .b_val       (b_val),
        .b_last      (b_last),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_matches (res_matches),
        .eq          (eq),
        .res_ovf     (res_ovf)
    );

    always #5 clk = ~clk;

    function automatic elem_t mk(input bit l, input int i, input int v);
        elem_t e;
        e.last = l;
        e.idx  = 3'(i);
        e.val  = 3'(v);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Streams both lists (entered #1 after a rising edge), returns at the negedge where
    // res_valid is first seen, and checks result, match count, eq pulses and latency.
    task automatic run_lists(input string tag, input int exp_data, input int exp_matches,
                             input int exp_eq);
        int ai = 0, bi = 0, cyc = 0, last_hs = -100, eqc = 0;
        bit ar, br, got = 0;
        while (cyc < 40 && !got) begin
            a_valid = (ai < na);
            b_valid = (bi < nb);
            {a_last, a_idx, a_val} = (ai < na) ? a_list[ai] : '0;
            {b_last, b_idx, b_val} = (bi < nb) ? b_list[bi] : '0;
            @(negedge clk);
            ar = a_ready;
            br = b_ready;
            if (eq) eqc++;
            if (res_valid) begin
                got = 1;
            end else begin
                @(posedge clk);
                #1;
                if (ar) ai++;
                if (br) bi++;
                if (ar || br) last_hs = cyc;
                cyc++;
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        check({tag, "_done"},    32'(got),             32'd1);
        check({tag, "_data"},    32'(res_data),        32'(exp_data));
        check({tag, "_matches"}, 32'(res_matches),     32'(exp_matches));
        check({tag, "_eq"},      32'(eqc),             32'(exp_eq));
        check({tag, "_a_used"},  32'(ai),              32'(na));
        check({tag, "_b_used"},  32'(bi),              32'(nb));
        check({tag, "_latency"}, 32'(cyc - last_hs),   32'd1);
    endtask

    // Called at the negedge inside OUT: completes the result handshake.
    task automatic accept(input string tag);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        a_idx     = '0;
        a_val     = '0;
        a_last    = 1'b0;
        b_idx     = '0;
        b_val     = '0;
        b_last    = 1'b0;
        res_ready = 1'b0;

        #12;
        check("rst_valid",   32'(res_valid),   32'd0);
        check("rst_data",    32'(res_data),    32'd0);
        check("rst_matches", 32'(res_matches), 32'd0);
        check("rst_eq",      32'(eq),          32'd0);
        check("rst_ovf",     32'(res_ovf),     32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Scenario 1: 3*2 + 5*7 = 41.
        a_list[0] = mk(0, 1, 3); a_list[1] = mk(1, 4, 5); na = 2;
        b_list[0] = mk(0, 1, 2); b_list[1] = mk(1, 4, 7); nb = 2;
        run_lists("s1", 41, 2, 2);
        check("s1_ovf", 32'(res_ovf), 32'd0);
        accept("s1");

        // Disjoint lists: no match.
        a_list[0] = mk(0, 0, 7); a_list[1] = mk(1, 2, 7); na = 2;
        b_list[0] = mk(0, 1, 7); b_list[1] = mk(1, 3, 7); nb = 2;
        run_lists("disj", 0, 0, 0);
        accept("disj");

        // A ends early; B drains its tail.
        a_list[0] = mk(1, 5, 7); na = 1;
        b_list[0] = mk(0, 0, 1); b_list[1] = mk(0, 5, 7); b_list[2] = mk(1, 6, 3); nb = 3;
        run_lists("aend", 49, 1, 1);

        // Backpressure in OUT with live upstream valids.
        a_valid = 1'b1; a_idx = '0; a_val = 3'd1; a_last = 1'b0;
        b_valid = 1'b1; b_idx = '0; b_val = 3'd1; b_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",   32'(res_valid),   32'd1);
            check("bp_data",    32'(res_data),    32'd49);
            check("bp_matches", 32'(res_matches), 32'd1);
            check("bp_a_ready", 32'(a_ready),     32'd0);
            check("bp_b_ready", 32'(b_ready),     32'd0);
            @(negedge clk);
        end
        accept("bp");
        check("bp_run_a_ready", 32'(a_ready), 32'd1);
        check("bp_run_data",    32'(res_data), 32'd0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        #1;

        // Six 7*7 matches: 294 wraps to 38, or saturates to 255 with the option.
        for (int i = 0; i < 6; i++) begin
            a_list[i] = mk(i == 5, i, 7);
            b_list[i] = mk(i == 5, i, 7);
        end
        na = 6;
        nb = 6;
`ifdef SPARSE_DOT_ACC_SAT_EN
        run_lists("ovf", 255, 6, 6);
        check("ovf_flag", 32'(res_ovf), 32'd1);
`else
        run_lists("ovf", 38, 6, 6);
        check("ovf_flag", 32'(res_ovf), 32'd0);
`endif
        accept("ovf");
        check("ovf_flag_clr", 32'(res_ovf), 32'd0);

        // Reset after the first match of scenario 1, then a full restart.
        a_valid = 1'b1; {a_last, a_idx, a_val} = mk(0, 1, 3);
        b_valid = 1'b1; {b_last, b_idx, b_val} = mk(0, 1, 2);
        @(negedge clk);
        check("mid_match_ready", 32'(a_ready && b_ready), 32'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("mid_eq",      32'(eq),          32'd1);
        check("mid_matches", 32'(res_matches), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid",   32'(res_valid),   32'd0);
        check("mid_rst_data",    32'(res_data),    32'd0);
        check("mid_rst_matches", 32'(res_matches), 32'd0);
        check("mid_rst_eq",      32'(eq),          32'd0);
        check("mid_rst_ovf",     32'(res_ovf),     32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        a_list[0] = mk(0, 1, 3); a_list[1] = mk(1, 4, 5); na = 2;
        b_list[0] = mk(0, 1, 2); b_list[1] = mk(1, 4, 7); nb = 2;
        run_lists("restart", 41, 2, 2);
        accept("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
